// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: stage occupancy states and the RV32 NOP encoding.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } stage_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register (main + skid) with flush and a saturating bubble counter.
// Outputs always come from the main entry; the skid entry absorbs one beat of back-pressure.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 72,
    parameter logic [31:0] NOP_INSTR = RV32_NOP,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_pc,
    input  logic [31:0]          i_instr,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_instr,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [CNT_W-1:0]     o_bubble_cnt
);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    localparam entry_t EmptyEntry = '{pc: '0, instr: NOP_INSTR, payload: '0};

    stage_state_e     state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;

    assign o_valid  = (state_q != StEmpty);
    assign o_ready  = (state_q != StTwo);
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign in_entry = '{pc: i_pc, instr: i_instr, payload: i_payload};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            // Flush wins over any same-cycle input; an output fire is simply consumed.
            state_d = StEmpty;
            main_d  = EmptyEntry;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = StTwo;
                    end else if (out_fire) begin
                        main_d  = EmptyEntry;
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: begin
                    main_d  = EmptyEntry;
                    skid_d  = '0;
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!o_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StEmpty;
            main_q  <= EmptyEntry;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pc         = main_q.pc;
    assign o_instr      = main_q.instr;
    assign o_payload    = main_q.payload;
    assign o_bubble_cnt = cnt_q;

endmodule
